// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared types, constants and metric helpers for the K=3 rate-1/2 Viterbi decoder
package viterbi_pkg;
  localparam int NUM_STATES = 4;
  localparam int K = 3;
  typedef logic [1:0] vstate_t;
  typedef enum logic [1:0] {IDLE, ACS, TRACE, DONE} fsm_t;
  function automatic logic [1:0] code_pair(vstate_t s, logic u, logic [2:0] g0, logic [2:0] g1);
    return {^(g0 & {u, s}), ^(g1 & {u, s})};
  endfunction
  function automatic logic [1:0] hamming(logic [1:0] a, logic [1:0] b);
    return {&(a ^ b), ^(a ^ b)};
  endfunction
endpackage

// File: rtl/viterbi_acs_unit.sv
// viterbi_acs_unit: add-compare-select for one next state; ports pm0_i/pm1_i, bm0_i/bm1_i in, saturated pm_o and decision dec_o out
module viterbi_acs_unit #(
  parameter int PM_W = 6
) (
  input  logic [PM_W-1:0] pm0_i,
  input  logic [PM_W-1:0] pm1_i,
  input  logic [1:0]      bm0_i,
  input  logic [1:0]      bm1_i,
  output logic [PM_W-1:0] pm_o,
  output logic            dec_o
);
  localparam logic [PM_W-1:0] PM_MAX = '1;
  logic [PM_W:0] sum0, sum1;
  logic [PM_W-1:0] cand0, cand1;
  assign sum0 = {1'b0, pm0_i} + {{(PM_W-1){1'b0}}, bm0_i};
  assign sum1 = {1'b0, pm1_i} + {{(PM_W-1){1'b0}}, bm1_i};
  assign cand0 = sum0[PM_W] ? PM_MAX : sum0[PM_W-1:0];
  assign cand1 = sum1[PM_W] ? PM_MAX : sum1[PM_W-1:0];
  assign dec_o = cand1 < cand0;
  assign pm_o = dec_o ? cand1 : cand0;
endmodule

// File: rtl/viterbi_stream_decoder.sv
// viterbi_stream_decoder: streaming hard-decision K=3 Viterbi decoder; st starts a block, sym_in/sym_valid/sym_ready feed pairs, data_out/err_metric/done report the result, busy covers ACS and TRACE
module viterbi_stream_decoder
  import viterbi_pkg::*;
#(
  parameter int         N_BITS = 10,
  parameter logic [2:0] G0     = 3'b111,
  parameter logic [2:0] G1     = 3'b101,
  parameter int         PM_W   = 6,
  parameter bit         TAIL   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st,
  input  logic [1:0]        sym_in,
  input  logic              sym_valid,
  output logic              sym_ready,
  output logic              busy,
  output logic [N_BITS-1:0] data_out,
  output logic [PM_W-1:0]   err_metric,
  output logic              done
);
  localparam int TW = $clog2(N_BITS);
  localparam logic [PM_W-1:0] PM_INF = '1;
  localparam logic [TW-1:0] T_LAST = TW'(N_BITS - 1);
  fsm_t state_q, state_d;
  logic [PM_W-1:0] pm_q [NUM_STATES];
  logic [PM_W-1:0] pm_new [NUM_STATES];
  logic [NUM_STATES-1:0] dec_new;
  logic [NUM_STATES-1:0] surv_q [N_BITS];
  logic [TW-1:0] t_q;
  vstate_t s_q, start;
  logic [N_BITS-1:0] data_q;
  logic [PM_W-1:0] err_q;
  logic acc, last;
  for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
    // next state n = {u, s1}; predecessors differ only in s0
    localparam vstate_t P0 = vstate_t'(2 * (n % 2));
    localparam vstate_t P1 = vstate_t'(2 * (n % 2) + 1);
    localparam logic U = (n >= 2);
    viterbi_acs_unit #(.PM_W(PM_W)) u_acs (
      .pm0_i(pm_q[P0]),
      .pm1_i(pm_q[P1]),
      .bm0_i(hamming(sym_in, code_pair(P0, U, G0, G1))),
      .bm1_i(hamming(sym_in, code_pair(P1, U, G0, G1))),
      .pm_o (pm_new[n]),
      .dec_o(dec_new[n])
    );
  end
  assign acc = (state_q == ACS) && sym_valid;
  assign last = acc && (t_q == T_LAST);
  // traceback origin is chosen from the metrics produced by the final symbol
  always_comb begin
    vstate_t m01, m23, best;
    m01 = (pm_new[1] < pm_new[0]) ? 2'd1 : 2'd0;
    m23 = (pm_new[3] < pm_new[2]) ? 2'd3 : 2'd2;
    best = (pm_new[m23] < pm_new[m01]) ? m23 : m01;
    start = TAIL ? 2'd0 : best;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = st ? ACS : IDLE;
      ACS:     state_d = last ? TRACE : ACS;
      TRACE:   state_d = (t_q == '0) ? DONE : TRACE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q <= '0;
      s_q <= '0;
      data_q <= '0;
      err_q <= '0;
      for (int i = 0; i < NUM_STATES; i++) pm_q[i] <= '0;
      for (int i = 0; i < N_BITS; i++) surv_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && st) begin
        t_q <= '0;
        for (int i = 0; i < NUM_STATES; i++) pm_q[i] <= (i == 0) ? '0 : PM_INF;
      end
      if (acc) begin
        for (int i = 0; i < NUM_STATES; i++) pm_q[i] <= pm_new[i];
        surv_q[t_q] <= dec_new;
        t_q <= last ? t_q : t_q + 1'b1;
        if (last) begin
          s_q <= start;
          err_q <= pm_new[start];
        end
      end
      if (state_q == TRACE) begin
        data_q[t_q] <= s_q[1];
        s_q <= {s_q[0], surv_q[t_q][s_q]};
        t_q <= t_q - 1'b1;
      end
    end
  end
  assign sym_ready = state_q == ACS;
  assign busy = (state_q == ACS) || (state_q == TRACE);
  assign done = state_q == DONE;
  assign data_out = data_q;
  assign err_metric = err_q;
endmodule

// File: tb/tb_viterbi_stream_decoder.sv
// tb_viterbi_stream_decoder: directed scoreboard bench for the streaming Viterbi decoder
module tb_viterbi_stream_decoder;
  typedef struct packed {logic [63:0] d; logic [63:0] e;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic st0 = 1'b0, st1 = 1'b0, v0 = 1'b0, v1 = 1'b0;
  logic [1:0] s0 = 2'b00, s1 = 2'b00;
  logic r0, r1, b0, b1, d0, d1;
  logic [9:0] data0;
  logic [3:0] data1;
  logic [5:0] e0, e1;
  int n_cmp = 0, n_bad = 0, cyc = 0, acc0 = 0, acc1 = 0, dn0 = 0, dn1 = 0;
  exp_t q0[$], q1[$];
  logic [1:0] clean [10] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [1:0] zeros [10] = '{default: 2'b00};
  logic [1:0] noisy [10];
  logic [1:0] short4 [4] = '{2'b11, 2'b10, 2'b00, 2'b01};

  viterbi_stream_decoder u_dut (
    .clk(clk), .rst(rst), .st(st0), .sym_in(s0), .sym_valid(v0), .sym_ready(r0),
    .busy(b0), .data_out(data0), .err_metric(e0), .done(d0)
  );
  viterbi_stream_decoder #(.N_BITS(4), .TAIL(1'b0)) u_dut4 (
    .clk(clk), .rst(rst), .st(st1), .sym_in(s1), .sym_valid(v1), .sym_ready(r1),
    .busy(b1), .data_out(data1), .err_metric(e1), .done(d1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (!rst && d0) begin
    exp_t x;
    if (q0.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_done0: got done=1 expected 0");
    end else begin
      x = q0.pop_front();
      chk("data0", 64'(data0), x.d);
      chk("err0", 64'(e0), x.e);
      chk("latency0", 64'(cyc - acc0), 64'd10);
    end
    dn0++;
  end

  always @(negedge clk) if (!rst && d1) begin
    exp_t x;
    if (q1.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_done1: got done=1 expected 0");
    end else begin
      x = q1.pop_front();
      chk("data1", 64'(data1), x.d);
      chk("err1", 64'(e1), x.e);
      chk("latency1", 64'(cyc - acc1), 64'd4);
    end
    dn1++;
  end

  task automatic start(input int w);
    if (w == 0) st0 = 1'b1; else st1 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    st1 = 1'b0;
  endtask

  task automatic send(input int w, input logic [1:0] sym);
    int g = 0;
    if (w == 0) begin s0 = sym; v0 = 1'b1; end else begin s1 = sym; v1 = 1'b1; end
    while (!(w == 0 ? r0 : r1) && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!(w == 0 ? r0 : r1)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout%0d: got ready=0 expected 1", w);
    end else begin
      @(posedge clk);
      #1;
      if (w == 0) acc0 = cyc; else acc1 = cyc;
    end
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic wait_done(input int w, input int prev);
    int g = 0;
    while ((w == 0 ? dn0 : dn1) == prev && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("done_seen", 64'(w == 0 ? dn0 : dn1), 64'(prev + 1));
  endtask

  task automatic block0(input logic [1:0] sy [10], input int gapmax, input logic [63:0] ed, input logic [63:0] ee);
    int p = dn0;
    q0.push_back(exp_t'{d: ed, e: ee});
    start(0);
    chk("busy_acs", 64'(b0), 64'd1);
    chk("ready_acs", 64'(r0), 64'd1);
    for (int i = 0; i < 10; i++) begin
      if (gapmax > 0 && i > 0) repeat ($urandom_range(1, gapmax)) @(negedge clk);
      send(0, sy[i]);
    end
    chk("ready_after_last", 64'(r0), 64'd0);
    chk("busy_trace", 64'(b0), 64'd1);
    wait_done(0, p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int p;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(r0), 64'd0);
    chk("rst_busy", 64'(b0), 64'd0);
    chk("rst_done", 64'(d0), 64'd0);
    chk("rst_data", 64'(data0), 64'd0);
    chk("rst_err", 64'(e0), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    block0(clean, 0, 64'h00D, 64'd0);
    noisy = clean;
    noisy[2] = 2'b10;
    block0(noisy, 0, 64'h00D, 64'd1);
    block0(clean, 3, 64'h00D, 64'd0);
    s0 = 2'b11;
    v0 = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready", 64'(r0), 64'd0);
    chk("idle_busy", 64'(b0), 64'd0);
    v0 = 1'b0;
    p = dn0;
    q0.push_back(exp_t'{d: 64'h00D, e: 64'd0});
    start(0);
    for (int i = 0; i < 5; i++) send(0, clean[i]);
    start(0);
    for (int i = 5; i < 10; i++) send(0, clean[i]);
    wait_done(0, p);
    start(0);
    for (int i = 0; i < 5; i++) send(0, clean[i]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(b0), 64'd0);
    chk("midrst_ready", 64'(r0), 64'd0);
    chk("midrst_data", 64'(data0), 64'd0);
    chk("midrst_err", 64'(e0), 64'd0);
    p = dn0;
    repeat (30) @(negedge clk);
    chk("midrst_no_done", 64'(dn0), 64'(p));
    block0(clean, 0, 64'h00D, 64'd0);
    block0(zeros, 0, 64'h000, 64'd0);
    p = dn1;
    q1.push_back(exp_t'{d: 64'hD, e: 64'd0});
    start(1);
    for (int i = 0; i < 4; i++) send(1, short4[i]);
    chk("ready_after_last4", 64'(r1), 64'd0);
    wait_done(1, p);
    repeat (3) @(negedge clk);
    chk("queue0_empty", 64'(q0.size()), 64'd0);
    chk("queue1_empty", 64'(q1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
